// File: rtl/activity_monitor.sv
// Player activity monitor: per-channel press edges, a stretched activity pulse and a BOOT/ACTIVE/IDLE tracker.
// Define ACTIVITY_DEBOUNCE_EN to put a per-channel debounce filter in front of edge detection.
module activity_monitor #(
   parameter int N_CH            = 6,
   parameter int PULSE_LEN       = 1,
   parameter int IDLE_CYCLES     = 50000000,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] s,
   output logic            R,
   output logic [N_CH-1:0] ch_hit,
   output logic            idle,
   output logic            wake
);

   localparam int PW = $clog2(PULSE_LEN + 1);
   localparam int TW = $clog2(IDLE_CYCLES + 1);
   localparam bit CFG_OK = (N_CH >= 1) && (N_CH <= 32) && (PULSE_LEN >= 1) &&
                           (IDLE_CYCLES >= 1) && (DEBOUNCE_CYCLES >= 1);

   typedef enum logic [1:0] {ST_BOOT, ST_ACTIVE, ST_IDLE} state_t;

   state_t          state_q, state_d;
   logic [N_CH-1:0] lvl;
   logic [N_CH-1:0] s_q;
   logic [N_CH-1:0] edge_c;
   logic [PW-1:0]   str_q, str_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic            r_q, idle_q, wake_q;
   logic [N_CH-1:0] ch_hit_q;
   logic            ev;

`ifdef ACTIVITY_DEBOUNCE_EN
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [N_CH-1:0] acc_q, acc_d;
   logic [DW-1:0]   db_cnt_q [N_CH];
   logic [DW-1:0]   db_cnt_d [N_CH];

   // Count consecutive raw samples that disagree with the accepted level; flip once the run is long enough.
   always_comb begin
      acc_d = acc_q;
      for (int i = 0; i < N_CH; i++) begin
         db_cnt_d[i] = '0;
         if (s[i] != acc_q[i]) begin
            if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1))
               acc_d[i] = s[i];
            else
               db_cnt_d[i] = db_cnt_q[i] + DW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_q <= '1;
         for (int i = 0; i < N_CH; i++) db_cnt_q[i] <= '0;
      end else begin
         acc_q <= acc_d;
         for (int i = 0; i < N_CH; i++) db_cnt_q[i] <= db_cnt_d[i];
      end
   end

   assign lvl = acc_q;
`else
   assign lvl = s;
`endif

   assign edge_c = lvl & ~s_q;
   assign ev     = (|edge_c) | (state_q == ST_BOOT);

   always_comb begin
      str_d = str_q;
      if (ev)
         str_d = PW'(PULSE_LEN);
      else if (str_q != '0)
         str_d = str_q - PW'(1);

      tmr_d = tmr_q;
      if (ev)
         tmr_d = '0;
      else if (tmr_q != TW'(IDLE_CYCLES))
         tmr_d = tmr_q + TW'(1);

      // An event on the saturating edge keeps the timer at zero, so ACTIVE wins automatically.
      state_d = state_q;
      case (state_q)
         ST_BOOT:   state_d = ST_ACTIVE;
         ST_ACTIVE: if (tmr_d == TW'(IDLE_CYCLES)) state_d = ST_IDLE;
         ST_IDLE:   if (ev) state_d = ST_ACTIVE;
         default:   state_d = ST_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_BOOT;
         s_q      <= '1;
         str_q    <= '0;
         tmr_q    <= '0;
         r_q      <= 1'b0;
         ch_hit_q <= '0;
         idle_q   <= 1'b0;
         wake_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         s_q      <= lvl;
         str_q    <= str_d;
         tmr_q    <= tmr_d;
         r_q      <= (str_d != '0);
         ch_hit_q <= edge_c;
         idle_q   <= (state_d == ST_IDLE);
         wake_q   <= (state_q == ST_IDLE) & ev;
      end
   end

   assign R      = r_q;
   assign ch_hit = ch_hit_q;
   assign idle   = idle_q;
   assign wake   = wake_q;

   // Parameter combinations outside the supported ranges are rejected here.
   a_cfg_ok: assert property (@(posedge clk) CFG_OK);

endmodule

// File: tb/tb_activity_monitor.sv
// Bench for activity_monitor: event-time reference model compared every cycle, plus directed literal checks.
module tb_activity_monitor;

   localparam int N_CH            = 6;
   localparam int PULSE_LEN       = 3;
   localparam int IDLE_CYCLES     = 8;
   localparam int DEBOUNCE_CYCLES = 4;

   logic            clk   = 1'b0;
   logic            reset = 1'b0;
   logic [N_CH-1:0] s     = '0;
   logic            R;
   logic [N_CH-1:0] ch_hit;
   logic            idle;
   logic            wake;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   activity_monitor #(
      .N_CH           (N_CH),
      .PULSE_LEN      (PULSE_LEN),
      .IDLE_CYCLES    (IDLE_CYCLES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .s     (s),
      .R     (R),
      .ch_hit(ch_hit),
      .idle  (idle),
      .wake  (wake)
   );

   // Reference model: tracks the edge index of the latest event and derives outputs from elapsed time.
   logic [N_CH-1:0] m_prev   = '1;
   logic [N_CH-1:0] m_hit    = '0;
   logic [N_CH-1:0] m_lvl    = '0;
   bit              m_booted = 1'b0;
   int              m_t      = 0;
   int              m_last   = 0;
   bit              m_R      = 1'b0;
   bit              m_idle   = 1'b0;
   bit              m_wake   = 1'b0;
   bit              m_ev     = 1'b0;
   bit              m_was_idle = 1'b0;
`ifdef ACTIVITY_DEBOUNCE_EN
   logic [N_CH-1:0] m_acc = '1;
   logic [N_CH-1:0] m_win[$];
   bit              m_same;
`endif

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_prev   = '1;
         m_hit    = '0;
         m_booted = 1'b0;
         m_t      = 0;
         m_last   = 0;
         m_R      = 1'b0;
         m_idle   = 1'b0;
         m_wake   = 1'b0;
`ifdef ACTIVITY_DEBOUNCE_EN
         m_acc    = '1;
         m_win.delete();
`endif
      end else begin
`ifdef ACTIVITY_DEBOUNCE_EN
         m_lvl = m_acc;
         m_win.push_back(s);
         if (m_win.size() > DEBOUNCE_CYCLES) void'(m_win.pop_front());
         if (m_win.size() == DEBOUNCE_CYCLES) begin
            for (int c = 0; c < N_CH; c++) begin
               m_same = 1'b1;
               for (int k = 1; k < DEBOUNCE_CYCLES; k++)
                  if (m_win[k][c] != m_win[0][c]) m_same = 1'b0;
               if (m_same) m_acc[c] = m_win[0][c];
            end
         end
`else
         m_lvl = s;
`endif
         m_hit      = m_lvl & ~m_prev;
         m_prev     = m_lvl;
         m_t        = m_t + 1;
         m_ev       = (m_hit != '0) || !m_booted;
         m_booted   = 1'b1;
         m_was_idle = m_idle;
         if (m_ev) m_last = m_t;
         m_R    = (m_t - m_last) < PULSE_LEN;
         m_idle = (m_t - m_last) >= IDLE_CYCLES;
         m_wake = m_ev && m_was_idle;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("model_R",      32'(R),      32'(m_R));
      chk("model_ch_hit", 32'(ch_hit), 32'(m_hit));
      chk("model_idle",   32'(idle),   32'(m_idle));
      chk("model_wake",   32'(wake),   32'(m_wake));
   end

   task automatic cyc(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic drv(input logic [N_CH-1:0] v);
      #1 s = v;
   endtask

   int r;

   initial begin
      cyc(3);
      chk("rst_R",      32'(R),      32'd0);
      chk("rst_ch_hit", 32'(ch_hit), 32'd0);
      chk("rst_idle",   32'(idle),   32'd0);
      chk("rst_wake",   32'(wake),   32'd0);
      #1 reset = 1'b1;
      cyc(1);
      chk("boot_R1",     32'(R),      32'd1);
      chk("boot_ch_hit", 32'(ch_hit), 32'd0);
      chk("boot_wake",   32'(wake),   32'd0);
      cyc(1);
      chk("boot_R2", 32'(R), 32'd1);
      cyc(1);
      chk("boot_R3", 32'(R), 32'd1);
      cyc(1);
      chk("boot_R_end", 32'(R), 32'd0);

`ifndef ACTIVITY_DEBOUNCE_EN
      drv(6'b000100);
      cyc(1);
      chk("press2_hit", 32'(ch_hit), 32'h04);
      chk("press2_R1",  32'(R),      32'd1);
      cyc(1);
      chk("press2_once", 32'(ch_hit), 32'd0);
      chk("press2_R2",   32'(R),      32'd1);
      cyc(1);
      chk("press2_R3", 32'(R), 32'd1);
      cyc(1);
      chk("press2_R_end", 32'(R), 32'd0);
      cyc(16);
      chk("hold_no_repeat", 32'(ch_hit), 32'd0);
      chk("hold_idle",      32'(idle),   32'd1);
      drv(6'b000000);
      cyc(2);
      chk("release_idle", 32'(idle), 32'd1);

      drv(6'b001000);
      cyc(1);
      chk("wake_idle", 32'(idle),   32'd0);
      chk("wake_wake", 32'(wake),   32'd1);
      chk("wake_hit",  32'(ch_hit), 32'h08);
      cyc(1);
      chk("wake_once", 32'(wake), 32'd0);
      drv(6'b000000);
      cyc(4);

      drv(6'b100001);
      cyc(1);
      chk("multi_hit", 32'(ch_hit), 32'h21);
      chk("multi_R1",  32'(R),      32'd1);
      cyc(1);
      chk("multi_R2", 32'(R), 32'd1);
      drv(6'b100011);
      cyc(1);
      chk("second_hit", 32'(ch_hit), 32'h02);
      chk("second_R1",  32'(R),      32'd1);
      cyc(1);
      chk("second_R2", 32'(R), 32'd1);
      cyc(1);
      chk("second_R3", 32'(R), 32'd1);
      cyc(1);
      chk("second_R_end", 32'(R), 32'd0);
      cyc(4);
      chk("tie_pre_idle", 32'(idle), 32'd0);
      drv(6'b100111);
      cyc(1);
      chk("tie_idle", 32'(idle),   32'd0);
      chk("tie_wake", 32'(wake),   32'd0);
      chk("tie_hit",  32'(ch_hit), 32'h04);
      drv(6'b000000);
`else
      for (int i = 0; i < 10; i++) begin
         drv((i % 2 == 0) ? 6'b010000 : 6'b000000);
         cyc(1);
         chk("toggle_hit", 32'(ch_hit), 32'd0);
      end
      drv(6'b010000);
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         chk("db_wait_hit", 32'(ch_hit), 32'd0);
      end
      cyc(1);
      chk("db_hit", 32'(ch_hit), 32'h10);
      cyc(1);
      chk("db_once", 32'(ch_hit), 32'd0);
      cyc(10);
      chk("db_hold", 32'(ch_hit), 32'd0);
      drv(6'b000000);
`endif

      cyc(1);
      #1 reset = 1'b0;
      s = 6'b111111;
      cyc(2);
      #1 reset = 1'b1;
      cyc(1);
      chk("held_boot_R",   32'(R),      32'd1);
      chk("held_boot_hit", 32'(ch_hit), 32'd0);
      cyc(1);
      chk("held_no_hit", 32'(ch_hit), 32'd0);
      chk("held_R2",     32'(R),      32'd1);
      #1 reset = 1'b0;
      #1;
      chk("async_R",    32'(R),      32'd0);
      chk("async_idle", 32'(idle),   32'd0);
      chk("async_hit",  32'(ch_hit), 32'd0);
      cyc(2);
      #1 reset = 1'b1;

      for (int n = 0; n < 1500; n++) begin
         cyc(1);
         #1;
         r = $urandom_range(0, 99);
         if (r < 8)
            s = N_CH'($urandom);
         else if (r < 14)
            s = s & N_CH'($urandom);
         if (r == 99) begin
            #2 reset = 1'b0;
            #3 reset = 1'b1;
         end
      end

      cyc(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
